cndm_pcie_msi_ctrl: RTL and testbench

- MSI interrupt controller between the cndm core's per-queue/event IRQ sources and the UltraScale+ PCIe hard IP cfg_interrupt_msi_* interface.
- Collects IRQ pulses into a pending register, applies the host mask and multiple-message-enable folding, and arbitrates round-robin.
- Issues one MSI at a time and retries on fail or timeout.
- Physical function 0 only.

---
 rtl/cndm_pcie_msi_ctrl_if.sv | 46 ++++
 rtl/cndm_pcie_msi_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cndm_pcie_msi_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cndm_pcie_msi_ctrl_if.sv
// MSI request/status bundle between the cndm MSI controller (master) and the
// UltraScale+ PCIe hard IP cfg_interrupt_msi_* port (slave).
interface cndm_pcie_msi_ctrl_if;
  logic [3:0]  cfg_interrupt_msi_enable;
  logic [11:0] cfg_interrupt_msi_mmenable;
  logic        cfg_interrupt_msi_mask_update;
  logic [31:0] cfg_interrupt_msi_data;
  logic [1:0]  cfg_interrupt_msi_select;
  logic [31:0] cfg_interrupt_msi_int;
  logic [31:0] cfg_interrupt_msi_pending_status;
  logic        cfg_interrupt_msi_pending_status_data_enable;
  logic [1:0]  cfg_interrupt_msi_pending_status_function_num;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [2:0]  cfg_interrupt_msi_attr;
  logic        cfg_interrupt_msi_tph_present;
  logic [1:0]  cfg_interrupt_msi_tph_type;
  logic [7:0]  cfg_interrupt_msi_tph_st_tag;
  logic [7:0]  cfg_interrupt_msi_function_number;

  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );

  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );
endinterface

// File: rtl/cndm_pcie_msi_ctrl.sv
// PF0 MSI controller: pending/mask/fold, round-robin issue, retry on fail/timeout.
// Optional statistics counters enabled by defining CNDM_MSI_STATS_EN.
module cndm_pcie_msi_ctrl #(
  parameter int unsigned IRQ_CNT         = 32,
  parameter int unsigned TIMEOUT_CYC     = 1024,
  parameter int unsigned RETRY_DELAY_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IRQ_CNT-1:0]       irq,
  cndm_pcie_msi_ctrl_if.master     msi,
  output logic [15:0]              stat_sent_cnt,
  output logic [15:0]              stat_fail_cnt
);

  localparam int unsigned VEC_CNT = 32;
  localparam int unsigned VEC_W   = 5;
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > RETRY_DELAY_CYC) ? TIMEOUT_CYC : RETRY_DELAY_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_BACKOFF = 2'd3;

  logic [1:0]         r_state,   w_state_nxt;
  logic [VEC_CNT-1:0] r_pending, w_pend_nxt;
  logic [VEC_CNT-1:0] r_mask,    w_mask_nxt;
  logic [VEC_W-1:0]   r_rr_ptr,  w_rr_nxt;
  logic [VEC_W-1:0]   r_cur,     w_cur_nxt;
  logic [TMR_W-1:0]   r_timer,   w_timer_nxt;
  logic [VEC_CNT-1:0] r_msi_int, w_int_nxt;
  logic               r_pend_de;

  logic [2:0]         w_fmm;
  logic [VEC_W-1:0]   w_fmask;
  logic [VEC_CNT-1:0] w_irq_fold;
  logic [VEC_CNT-1:0] w_elig;
  logic [VEC_CNT-1:0] w_clr;
  logic [VEC_W-1:0]   w_sel;
  logic               w_sel_vld;
  logic               w_tmo;
  logic               w_unused;

  assign w_unused = ^{msi.cfg_interrupt_msi_enable[3:1], msi.cfg_interrupt_msi_mmenable[11:3]};

  // Fold source index onto the allocated vector range (mmenable capped at 32 vectors)
  always_comb begin : fold
    w_fmm      = (msi.cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : msi.cfg_interrupt_msi_mmenable[2:0];
    w_fmask    = VEC_W'((32'd1 << w_fmm) - 32'd1);
    w_irq_fold = '0;
    for (int i = 0; i < int'(IRQ_CNT); i++) begin
      if (irq[i]) w_irq_fold[VEC_W'(i) & w_fmask] = 1'b1;
    end
  end

  assign w_elig = r_pending & ~r_mask & {VEC_CNT{msi.cfg_interrupt_msi_enable[0]}};

  // Lowest eligible vector at or above rr_ptr, wrapping modulo 32
  always_comb begin : rr_pick
    logic [VEC_W-1:0] idx;
    idx       = '0;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int k = VEC_CNT - 1; k >= 0; k--) begin
      idx = r_rr_ptr + VEC_W'(k);
      if (w_elig[idx]) begin
        w_sel     = idx;
        w_sel_vld = 1'b1;
      end
    end
  end

  assign w_tmo = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_rr_nxt    = r_rr_ptr;
    w_timer_nxt = r_timer;
    w_int_nxt   = '0;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_cur_nxt   = w_sel;
          w_int_nxt   = 32'd1 << w_sel;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        // sent has priority over a simultaneous fail or timeout
        if (msi.cfg_interrupt_msi_sent) begin
          w_clr[r_cur] = 1'b1;
          w_rr_nxt     = r_cur + VEC_W'(1);
          w_state_nxt  = S_IDLE;
        end else if (msi.cfg_interrupt_msi_fail || w_tmo) begin
          w_timer_nxt = '0;
          w_state_nxt = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if (r_timer == TMR_W'(RETRY_DELAY_CYC - 1)) begin
          w_rr_nxt    = r_cur + VEC_W'(1);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // set wins over clear for the same vector
    w_pend_nxt = (r_pending & ~w_clr) | w_irq_fold;
    w_mask_nxt = msi.cfg_interrupt_msi_mask_update ? msi.cfg_interrupt_msi_data : r_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_mask    <= '0;
      r_rr_ptr  <= '0;
      r_cur     <= '0;
      r_timer   <= '0;
      r_msi_int <= '0;
      r_pend_de <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_mask    <= w_mask_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_cur     <= w_cur_nxt;
      r_timer   <= w_timer_nxt;
      r_msi_int <= w_int_nxt;
      r_pend_de <= (w_pend_nxt != r_pending);
    end
  end

  assign msi.cfg_interrupt_msi_int                        = r_msi_int;
  assign msi.cfg_interrupt_msi_pending_status             = r_pending;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = r_pend_de;
  assign msi.cfg_interrupt_msi_select                     = 2'd0;
  assign msi.cfg_interrupt_msi_pending_status_function_num = 2'd0;
  assign msi.cfg_interrupt_msi_attr                       = 3'd0;
  assign msi.cfg_interrupt_msi_tph_present                = 1'b0;
  assign msi.cfg_interrupt_msi_tph_type                   = 2'd0;
  assign msi.cfg_interrupt_msi_tph_st_tag                 = 8'd0;
  assign msi.cfg_interrupt_msi_function_number            = 8'd0;

`ifdef CNDM_MSI_STATS_EN
  logic        w_sent_acc;
  logic        w_fail_acc;
  logic [15:0] r_sent_cnt;
  logic [15:0] r_fail_cnt;

  assign w_sent_acc = (r_state == S_WAIT) && msi.cfg_interrupt_msi_sent;
  assign w_fail_acc = (r_state == S_WAIT) && !msi.cfg_interrupt_msi_sent &&
                      (msi.cfg_interrupt_msi_fail || w_tmo);

  // Saturating delivery statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sent_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      if (w_sent_acc && (r_sent_cnt != 16'hFFFF)) r_sent_cnt <= r_sent_cnt + 16'd1;
      if (w_fail_acc && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign stat_sent_cnt = r_sent_cnt;
  assign stat_fail_cnt = r_fail_cnt;
`else
  assign stat_sent_cnt = 16'd0;
  assign stat_fail_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cndm_pcie_msi_ctrl.sv
// Scoreboard bench for cndm_pcie_msi_ctrl: directed scenarios plus randomized
// IRQ/mask/mmenable rounds checked against a vector-set reference model.
module tb_cndm_pcie_msi_ctrl;
  localparam int TMO = 16;
  localparam int RTY = 8;

  typedef struct { int kind; int dly; } resp_t;  // kind: 0 sent, 1 fail, 2 no answer

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq = '0;
  logic [15:0] stat_sent_cnt, stat_fail_cnt;

  cndm_pcie_msi_ctrl_if msi_if ();

  cndm_pcie_msi_ctrl #(.IRQ_CNT(32), .TIMEOUT_CYC(TMO), .RETRY_DELAY_CYC(RTY)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .msi(msi_if),
    .stat_sent_cnt(stat_sent_cnt), .stat_fail_cnt(stat_fail_cnt)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  resp_t       plan_q[$];
  int          issue_cyc[$];
  int          m_ptr = 0;
  int          m_sent = 0;
  int          m_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: folding as a modulo over the allocated vector count
  function automatic logic [31:0] fold(input logic [31:0] b, input int mm);
    int n = 1 << ((mm > 5) ? 5 : mm);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r[i % n] = 1'b1;
    return r;
  endfunction

  // Reference model: serve a set of vectors in rotating order from the pointer
  function automatic void push_order(input logic [31:0] set);
    int start = m_ptr;
    for (int k = 0; k < 32; k++) begin
      int v = (start + k) % 32;
      if (set[v]) begin
        exp_q.push_back(32'd1 << v);
        m_ptr = (v + 1) % 32;
        m_sent++;
      end
    end
  endfunction

  // Monitor: every request seen on msi_int is compared against the scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (msi_if.cfg_interrupt_msi_int != '0) begin
        issue_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("msi_int_unexpected", msi_if.cfg_interrupt_msi_int, 32'd0);
        else chk("msi_int", msi_if.cfg_interrupt_msi_int, exp_q.pop_front());
      end
    end
  end

  // Host IP responder model
  initial begin : responder
    resp_t p;
    msi_if.cfg_interrupt_msi_sent = 1'b0;
    msi_if.cfg_interrupt_msi_fail = 1'b0;
    forever begin
      @(negedge clk);
      if (msi_if.cfg_interrupt_msi_int != '0) begin
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else begin p.kind = 0; p.dly = int'($urandom_range(1, 4)); end
        if (p.kind != 2) begin
          repeat (p.dly) @(negedge clk);
          if (p.kind == 0) msi_if.cfg_interrupt_msi_sent = 1'b1;
          else msi_if.cfg_interrupt_msi_fail = 1'b1;
          @(negedge clk);
          msi_if.cfg_interrupt_msi_sent = 1'b0;
          msi_if.cfg_interrupt_msi_fail = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one-cycle irq pulse; returns at the negedge of the following cycle
  task automatic pulse(input logic [31:0] b);
    @(negedge clk);
    irq = b;
    @(negedge clk);
    irq = '0;
  endtask

  task automatic mask_upd(input logic [31:0] m);
    @(negedge clk);
    msi_if.cfg_interrupt_msi_mask_update = 1'b1;
    msi_if.cfg_interrupt_msi_data = m;
    @(negedge clk);
    msi_if.cfg_interrupt_msi_mask_update = 1'b0;
    msi_if.cfg_interrupt_msi_data = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_stats(input string name);
`ifdef CNDM_MSI_STATS_EN
    chk({name, "_sent"}, 32'(stat_sent_cnt), 32'(m_sent));
    chk({name, "_fail"}, 32'(stat_fail_cnt), 32'(m_fail));
`else
    chk({name, "_sent"}, 32'(stat_sent_cnt), 32'd0);
    chk({name, "_fail"}, 32'(stat_fail_cnt), 32'd0);
`endif
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_int"}, msi_if.cfg_interrupt_msi_int, 32'd0);
    chk({name, "_pend"}, msi_if.cfg_interrupt_msi_pending_status, 32'd0);
    chk({name, "_de"}, 32'(msi_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
  endtask

  initial begin : stim
    logic [31:0] f, mk, b;
    int mm;
    msi_if.cfg_interrupt_msi_enable      = 4'h0;
    msi_if.cfg_interrupt_msi_mmenable    = 12'd5;
    msi_if.cfg_interrupt_msi_mask_update = 1'b0;
    msi_if.cfg_interrupt_msi_data        = '0;
    repeat (4) @(negedge clk);
    chk_idle("reset");
    chk("reset_consts", {22'd0, msi_if.cfg_interrupt_msi_select, msi_if.cfg_interrupt_msi_pending_status_function_num,
        msi_if.cfg_interrupt_msi_attr, msi_if.cfg_interrupt_msi_tph_present, msi_if.cfg_interrupt_msi_tph_type}, 32'd0);
    chk("reset_consts2", {16'd0, msi_if.cfg_interrupt_msi_tph_st_tag, msi_if.cfg_interrupt_msi_function_number}, 32'd0);
    chk_stats("reset_stats");
    rst_n = 1'b1;
    msi_if.cfg_interrupt_msi_enable = 4'h1;
    mask_upd(32'd0);

    // Basic issue: latency and pending_status/data_enable on set and clear
    plan_q.push_back('{0, 1});
    push_order(fold(32'h8, 5));
    pulse(32'h8);
    chk("s1_pend_set", msi_if.cfg_interrupt_msi_pending_status, 32'h8);
    chk("s1_de_set", 32'(msi_if.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
    @(negedge clk);
    chk("s1_latency", msi_if.cfg_interrupt_msi_int, 32'h8);
    chk("s1_de_quiet", 32'(msi_if.cfg_interrupt_msi_pending_status_data_enable), 32'd0);
    @(negedge clk);
    chk("s1_pend_wait", msi_if.cfg_interrupt_msi_pending_status, 32'h8);
    @(negedge clk);
    chk("s1_pend_clr", msi_if.cfg_interrupt_msi_pending_status, 32'd0);
    chk("s1_de_clr", 32'(msi_if.cfg_interrupt_msi_pending_status_data_enable), 32'd1);
    drain("s1_drain", 50);

    // Folding with four vectors
    msi_if.cfg_interrupt_msi_mmenable = 12'd2;
    push_order(fold(32'h40, 2));
    pulse(32'h40);
    chk("s2_pend_fold", msi_if.cfg_interrupt_msi_pending_status, 32'h4);
    @(negedge clk);
    chk("s2_latency", msi_if.cfg_interrupt_msi_int, 32'h4);
    drain("s2_drain", 50);

    // Round robin: move the pointer to 0, then two simultaneous sources
    msi_if.cfg_interrupt_msi_mmenable = 12'd5;
    push_order(32'h8000_0000);
    pulse(32'h8000_0000);
    drain("s3a_drain", 50);
    plan_q.push_back('{0, 3});
    plan_q.push_back('{0, 3});
    push_order(32'h202);
    pulse(32'h202);
    drain("s3_drain", 100);
    chk_stats("s3_stats");

    // Fail then retry after backoff
    issue_cyc.delete();
    plan_q.push_back('{1, 1});
    plan_q.push_back('{0, 1});
    exp_q.push_back(32'h10);
    m_fail++;
    push_order(32'h10);
    pulse(32'h10);
    drain("s4_drain", 100);
    chk("s4_issue_cnt", 32'(issue_cyc.size()), 32'd2);
    if (issue_cyc.size() == 2) chk("s4_retry_gap", 32'(issue_cyc[1] - issue_cyc[0]), 32'(RTY + 3));
    chk_stats("s4_stats");

    // Timeout then retry
    issue_cyc.delete();
    plan_q.push_back('{2, 0});
    plan_q.push_back('{0, 1});
    exp_q.push_back(32'h10);
    m_fail++;
    push_order(32'h10);
    pulse(32'h10);
    drain("s5_drain", 200);
    chk("s5_issue_cnt", 32'(issue_cyc.size()), 32'd2);
    if (issue_cyc.size() == 2) chk("s5_tmo_gap", 32'(issue_cyc[1] - issue_cyc[0]), 32'(TMO + RTY + 2));
    chk_stats("s5_stats");

    // Mask holds a pending vector until unmasked
    mask_upd(32'h10);
    pulse(32'h10);
    repeat (30) @(negedge clk);
    chk("s6_masked_pend", msi_if.cfg_interrupt_msi_pending_status, 32'h10);
    push_order(32'h10);
    mask_upd(32'd0);
    drain("s6_drain", 50);
    chk("s6_pend_clr", msi_if.cfg_interrupt_msi_pending_status, 32'd0);

    // Randomized rounds: mmenable, source set, mask, enable gating
    for (int r = 0; r < 24; r++) begin
      mm = int'($urandom_range(0, 7));
      b  = $urandom;
      if (r % 3 == 0) b = b & $urandom;
      mk = (r % 2 == 1) ? ($urandom & $urandom) : 32'd0;
      msi_if.cfg_interrupt_msi_mmenable = 12'(mm);
      msi_if.cfg_interrupt_msi_enable = (r % 4 == 3) ? 4'h0 : 4'h1;
      mask_upd(mk);
      f = fold(b, mm);
      if (r % 4 != 3) push_order(f & ~mk);
      pulse(b);
      chk("rand_pend_set", msi_if.cfg_interrupt_msi_pending_status, f);
      if (r % 4 == 3) begin
        repeat (10) @(negedge clk);
        chk("rand_disabled_pend", msi_if.cfg_interrupt_msi_pending_status, f);
        push_order(f & ~mk);
        msi_if.cfg_interrupt_msi_enable = 4'h1;
      end
      drain("rand_drain1", 400);
      chk("rand_masked_left", msi_if.cfg_interrupt_msi_pending_status, f & mk);
      push_order(f & mk);
      mask_upd(32'd0);
      drain("rand_drain2", 400);
      chk("rand_pend_empty", msi_if.cfg_interrupt_msi_pending_status, 32'd0);
    end
    chk_stats("rand_stats");

    // Reset during WAIT; late sent must be ignored
    msi_if.cfg_interrupt_msi_mmenable = 12'd5;
    plan_q.push_back('{0, 6});
    push_order(32'h20);
    pulse(32'h20);
    @(negedge clk);
    chk("s7_issue", msi_if.cfg_interrupt_msi_int, 32'h20);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_sent = 0; m_fail = 0;
    exp_q.delete();
    chk_idle("s7_in_reset");
    chk_stats("s7_reset_stats");
    repeat (10) @(negedge clk);
    chk_idle("s7_after_sent");
    chk_stats("s7_after_stats");
    push_order(32'h1);
    pulse(32'h1);
    chk("s7_pend_set", msi_if.cfg_interrupt_msi_pending_status, 32'h1);
    @(negedge clk);
    chk("s7_latency", msi_if.cfg_interrupt_msi_int, 32'h1);
    drain("s7_drain", 50);
    chk_stats("s7_final_stats");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
